// File: rtl/lattice_result_collector.sv
// lattice_result_collector
//
// Tail stage of the lattice chain. Counts the core results that arrive for
// the current round, buffers the successful nonces in a small FIFO and hands
// them to the host-side controller over a valid/ready handshake. It also
// reports round completion and FIFO overflow.
//
// Optional feature macro: LATTICE_COLLECTOR_DEDUP_EN
//   When defined, a success whose nonce matches the most recently pushed
//   nonce in the same round is silently discarded.
//
// Ports:
//   clk              sole clock, rising edge
//   rst              asynchronous, active-high reset
//   round_start_i    pulse: a new job entered the chain (restarts the round)
//   chain_valid_i    pulse: a core result is present on the chain outputs
//   chain_success_i  the current result is a hit
//   chain_core_i     index of the core that produced the result
//   chain_nonce_i    nonce of the result
//   host_valid_o     FIFO head is valid
//   host_ready_i     host accepts the head this cycle
//   host_nonce_o     head nonce (0 while empty)
//   host_core_o      head core index (0 while empty)
//   done_o           all results of the current round have arrived
//   overflow_o       sticky: a success was dropped because the FIFO was full
//   found_count_o    saturating count of successes pushed this round
module lattice_result_collector #(
  parameter int LOG2_NUM_CORES = 1,
  parameter int FIFO_DEPTH     = 4,
  parameter int NONCE_BITS     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      round_start_i,
  input  logic                      chain_valid_i,
  input  logic                      chain_success_i,
  input  logic [LOG2_NUM_CORES-1:0] chain_core_i,
  input  logic [NONCE_BITS-1:0]     chain_nonce_i,
  output logic                      host_valid_o,
  input  logic                      host_ready_i,
  output logic [NONCE_BITS-1:0]     host_nonce_o,
  output logic [LOG2_NUM_CORES-1:0] host_core_o,
  output logic                      done_o,
  output logic                      overflow_o,
  output logic [7:0]                found_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = LOG2_NUM_CORES + NONCE_BITS;

  // Number of results in one round, in the counter's own width.
  localparam logic [LOG2_NUM_CORES:0] NUM_RESULTS = {1'b1, {LOG2_NUM_CORES{1'b0}}};

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [1:0]              state;
  logic [LOG2_NUM_CORES:0] result_cnt;
  logic [LOG2_NUM_CORES:0] result_cnt_inc;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [EW-1:0] head;

  logic fifo_empty;
  logic fifo_full;
  logic accept;
  logic hit;
  logic dup;
  logic push;
  logic pop;
  logic drop;

  // A result only counts while collecting; a coincident round start wins
  // and throws the result away.
  assign accept         = (state == ST_COLLECT) && chain_valid_i && !round_start_i;
  assign result_cnt_inc = result_cnt + 1'b1;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // indices with differing wrap bits mean full.
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  assign pop  = !fifo_empty && host_ready_i;
  assign hit  = accept && chain_success_i && !dup;
  // A full FIFO still takes the new entry if the host frees a slot in the
  // same cycle, so throughput stays one push plus one pop per cycle.
  assign push = hit && (!fifo_full || pop);
  assign drop = hit && fifo_full && !pop;

`ifdef LATTICE_COLLECTOR_DEDUP_EN
  logic [NONCE_BITS-1:0] last_nonce;
  logic                  last_valid;

  assign dup = last_valid && (last_nonce == chain_nonce_i);

  // Remembers the most recently pushed nonce; forgotten at every round start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_nonce <= '0;
      last_valid <= 1'b0;
    end else if (round_start_i) begin
      last_valid <= 1'b0;
    end else if (push) begin
      last_nonce <= chain_nonce_i;
      last_valid <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // Round control: a round start from any state (including mid-round)
  // restarts collection; the edge accepting the last result enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      result_cnt <= '0;
    end else if (round_start_i) begin
      state      <= ST_COLLECT;
      result_cnt <= '0;
    end else if (accept) begin
      result_cnt <= result_cnt_inc;
      if (result_cnt_inc == NUM_RESULTS) begin
        state <= ST_DONE;
      end
    end
  end

  // Per-round flags: success count saturates at 255, overflow is sticky
  // until the next round start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      found_count_o <= 8'd0;
      overflow_o    <= 1'b0;
    end else if (round_start_i) begin
      found_count_o <= 8'd0;
      overflow_o    <= 1'b0;
    end else begin
      if (push && (found_count_o != 8'hFF)) begin
        found_count_o <= found_count_o + 8'd1;
      end
      if (drop) begin
        overflow_o <= 1'b1;
      end
    end
  end

  // FIFO pointers; round start deliberately leaves buffered entries alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= {chain_core_i, chain_nonce_i};
    end
  end

  assign head         = mem[rptr[AW-1:0]];
  assign host_valid_o = !fifo_empty;
  assign host_nonce_o = fifo_empty ? '0 : head[NONCE_BITS-1:0];
  assign host_core_o  = fifo_empty ? '0 : head[EW-1:NONCE_BITS];
  assign done_o       = (state == ST_DONE);

endmodule

// File: tb/tb_lattice_result_collector.sv
// Self-checking bench for lattice_result_collector (LOG2_NUM_CORES=1,
// FIFO_DEPTH=4, NONCE_BITS=32). A queue-based reference model tracks the
// expected FIFO contents and round flags from the block's behavioural rules.
module tb_lattice_result_collector;

  localparam int LOG2C = 1;
  localparam int NCORES = 2;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        roundStart;
  logic        chainValid;
  logic        chainSuccess;
  logic [0:0]  chainCore;
  logic [31:0] chainNonce;
  logic        hostValid;
  logic        hostReady;
  logic [31:0] hostNonce;
  logic [0:0]  hostCore;
  logic        done;
  logic        overflow;
  logic [7:0]  foundCount;

  int checks = 0;
  int fails = 0;

  lattice_result_collector #(
    .LOG2_NUM_CORES(LOG2C),
    .FIFO_DEPTH(DEPTH),
    .NONCE_BITS(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .round_start_i(roundStart),
    .chain_valid_i(chainValid),
    .chain_success_i(chainSuccess),
    .chain_core_i(chainCore),
    .chain_nonce_i(chainNonce),
    .host_valid_o(hostValid),
    .host_ready_i(hostReady),
    .host_nonce_o(hostNonce),
    .host_core_o(hostCore),
    .done_o(done),
    .overflow_o(overflow),
    .found_count_o(foundCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LATTICE_COLLECTOR_DEDUP_EN
  localparam bit DEDUP_EN = 1'b1;
`else
  localparam bit DEDUP_EN = 1'b0;
`endif

  // Reference model state
  typedef struct packed {
    logic [0:0]  core;
    logic [31:0] nonce;
  } entry_t;

  entry_t      mq[$];
  bit          mCollecting;
  bit          mDone;
  int          mSeen;
  int          mFound;
  bit          mOvf;
  logic [31:0] mLast;
  bit          mLastValid;

  typedef struct {
    bit          rs;
    bit          v;
    bit          s;
    logic [0:0]  core;
    logic [31:0] nonce;
    bit          rdy;
    bit          eValid;
    logic [31:0] eNonce;
    logic [0:0]  eCore;
    bit          eDone;
    bit          eOvf;
    logic [7:0]  eFound;
  } vec_t;

  task automatic modelReset();
    mq.delete();
    mCollecting = 0;
    mDone = 0;
    mSeen = 0;
    mFound = 0;
    mOvf = 0;
    mLast = '0;
    mLastValid = 0;
  endtask

  // Advances the model by one clock using the inputs about to be sampled.
  task automatic modelStep(bit rs, bit v, bit s, logic [0:0] core, logic [31:0] nonce, bit rdy);
    bit dupHit;
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (rs) begin
      mCollecting = 1;
      mDone = 0;
      mSeen = 0;
      mFound = 0;
      mOvf = 0;
      mLastValid = 0;
    end else if (mCollecting && v) begin
      mSeen++;
      if (s) begin
        dupHit = DEDUP_EN && mLastValid && (mLast == nonce);
        if (!dupHit) begin
          if (mq.size() < DEPTH) begin
            mq.push_back('{core: core, nonce: nonce});
            if (mFound < 255) mFound++;
            mLast = nonce;
            mLastValid = 1;
          end else begin
            mOvf = 1;
          end
        end
      end
      if (mSeen == NCORES) begin
        mCollecting = 0;
        mDone = 1;
      end
    end
  endtask

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs, steps the model, and samples 1 after the edge.
  task automatic applyStimulus(bit rs, bit v, bit s, logic [0:0] core, logic [31:0] nonce, bit rdy);
    roundStart = rs;
    chainValid = v;
    chainSuccess = s;
    chainCore = core;
    chainNonce = nonce;
    hostReady = rdy;
    modelStep(rs, v, s, core, nonce, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string name, bit ev, logic [31:0] en, logic [0:0] ec, bit ed, bit eo, logic [7:0] ef);
    cmp({name, ".valid"}, {31'd0, hostValid}, {31'd0, ev});
    cmp({name, ".nonce"}, hostNonce, en);
    cmp({name, ".core"}, {31'd0, hostCore}, {31'd0, ec});
    cmp({name, ".done"}, {31'd0, done}, {31'd0, ed});
    cmp({name, ".overflow"}, {31'd0, overflow}, {31'd0, eo});
    cmp({name, ".found"}, {24'd0, foundCount}, {24'd0, ef});
  endtask

  task automatic checkModel(string name);
    bit ev;
    ev = (mq.size() > 0);
    checkOutput(name, ev, ev ? mq[0].nonce : 32'd0, ev ? mq[0].core : 1'b0,
                mDone, mOvf, 8'(mFound));
  endtask

  task automatic stepChk(string name, bit rs, bit v, bit s, logic [0:0] core, logic [31:0] nonce, bit rdy);
    applyStimulus(rs, v, s, core, nonce, rdy);
    checkModel(name);
  endtask

  task automatic doReset();
    roundStart = 0;
    chainValid = 0;
    chainSuccess = 0;
    chainCore = '0;
    chainNonce = '0;
    hostReady = 0;
    rst = 1;
    modelReset();
    @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  // Pops entries one by one, checking each head against the expected order.
  task automatic drainExpect(string name, logic [31:0] e0, logic [31:0] e1, logic [31:0] e2, logic [31:0] e3);
    logic [31:0] exp[4];
    exp[0] = e0;
    exp[1] = e1;
    exp[2] = e2;
    exp[3] = e3;
    for (int k = 0; k < 4; k++) begin
      cmp($sformatf("%s.head%0d.valid", name, k), {31'd0, hostValid}, 32'd1);
      cmp($sformatf("%s.head%0d.nonce", name, k), hostNonce, exp[k]);
      applyStimulus(0, 0, 0, 1'b0, 32'd0, 1);
    end
    cmp({name, ".emptyAfter"}, {31'd0, hostValid}, 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int entries;
    rst = 1;
    modelReset();
    doReset();

    checkOutput("reset", 0, 32'd0, 1'b0, 0, 0, 8'd0);

    // Basic round: a miss, then a hit on core 1; host always ready.
    vecs[0] = '{1, 0, 0, 1'b0, 32'h0,    1, 0, 32'h0,    1'b0, 0, 0, 8'd0};
    vecs[1] = '{0, 1, 0, 1'b0, 32'h55,   1, 0, 32'h0,    1'b0, 0, 0, 8'd0};
    vecs[2] = '{0, 1, 1, 1'b1, 32'h1234, 1, 1, 32'h1234, 1'b1, 1, 0, 8'd1};
    vecs[3] = '{0, 0, 0, 1'b0, 32'h0,    1, 0, 32'h0,    1'b0, 1, 0, 8'd1};
    vecs[4] = '{0, 0, 0, 1'b0, 32'h0,    1, 0, 32'h0,    1'b0, 1, 0, 8'd1};
    vecs[5] = '{0, 1, 1, 1'b1, 32'h77,   1, 0, 32'h0,    1'b0, 1, 0, 8'd1};
    vecs[6] = '{1, 0, 0, 1'b0, 32'h0,    1, 0, 32'h0,    1'b0, 0, 0, 8'd0};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].rs, vecs[i].v, vecs[i].s, vecs[i].core, vecs[i].nonce, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].eValid, vecs[i].eNonce, vecs[i].eCore,
                  vecs[i].eDone, vecs[i].eOvf, vecs[i].eFound);
    end

    // Overflow across three rounds with the host stalled.
    doReset();
    stepChk("ovf.rs1", 1, 0, 0, 1'b0, 32'h0, 0);
    stepChk("ovf.h1", 0, 1, 1, 1'b0, 32'hA1, 0);
    stepChk("ovf.h2", 0, 1, 1, 1'b1, 32'hA2, 0);
    stepChk("ovf.rs2", 1, 0, 0, 1'b0, 32'h0, 0);
    stepChk("ovf.h3", 0, 1, 1, 1'b0, 32'hA3, 0);
    stepChk("ovf.h4", 0, 1, 1, 1'b1, 32'hA4, 0);
    stepChk("ovf.rs3", 1, 0, 0, 1'b0, 32'h0, 0);
    stepChk("ovf.h5", 0, 1, 1, 1'b0, 32'hA5, 0);
    cmp("ovf.flag", {31'd0, overflow}, 32'd1);
    cmp("ovf.found", {24'd0, foundCount}, 32'd0);
    drainExpect("ovf.drain", 32'hA1, 32'hA2, 32'hA3, 32'hA4);

    // Full FIFO with a simultaneous pop and push.
    doReset();
    stepChk("fp.rs1", 1, 0, 0, 1'b0, 32'h0, 0);
    stepChk("fp.h1", 0, 1, 1, 1'b0, 32'hB1, 0);
    stepChk("fp.h2", 0, 1, 1, 1'b1, 32'hB2, 0);
    stepChk("fp.rs2", 1, 0, 0, 1'b0, 32'h0, 0);
    stepChk("fp.h3", 0, 1, 1, 1'b0, 32'hB3, 0);
    stepChk("fp.h4", 0, 1, 1, 1'b1, 32'hB4, 0);
    stepChk("fp.rs3", 1, 0, 0, 1'b0, 32'h0, 0);
    stepChk("fp.h5", 0, 1, 1, 1'b1, 32'hB5, 1);
    cmp("fp.overflow", {31'd0, overflow}, 32'd0);
    cmp("fp.found", {24'd0, foundCount}, 32'd1);
    drainExpect("fp.drain", 32'hB2, 32'hB3, 32'hB4, 32'hB5);

    // Round start colliding with a valid hit: the hit is discarded.
    doReset();
    stepChk("col.rs0", 1, 0, 0, 1'b0, 32'h0, 1);
    stepChk("col.v0", 0, 1, 0, 1'b0, 32'h0, 1);
    stepChk("col.rsv", 1, 1, 1, 1'b1, 32'hC1, 1);
    cmp("col.noPush", {31'd0, hostValid}, 32'd0);
    cmp("col.done0", {31'd0, done}, 32'd0);
    stepChk("col.v1", 0, 1, 0, 1'b0, 32'h0, 1);
    cmp("col.done1", {31'd0, done}, 32'd0);
    stepChk("col.v2", 0, 1, 0, 1'b1, 32'h0, 1);
    cmp("col.done2", {31'd0, done}, 32'd1);

    // Asynchronous reset mid-round with two entries buffered.
    doReset();
    stepChk("ar.rs1", 1, 0, 0, 1'b0, 32'h0, 0);
    stepChk("ar.h1", 0, 1, 1, 1'b0, 32'hD1, 0);
    stepChk("ar.h2", 0, 1, 1, 1'b1, 32'hD2, 0);
    stepChk("ar.rs2", 1, 0, 0, 1'b0, 32'h0, 0);
    stepChk("ar.v", 0, 1, 0, 1'b0, 32'h0, 0);
    #2;
    rst = 1;
    modelReset();
    #1;
    checkOutput("ar.async", 0, 32'd0, 1'b0, 0, 0, 8'd0);
    #1;
    rst = 0;
    stepChk("ar.idle", 0, 1, 1, 1'b1, 32'hD3, 0);
    stepChk("ar.idle2", 0, 1, 1, 1'b0, 32'hD4, 0);
    cmp("ar.stillIdle", {31'd0, done}, 32'd0);

    // Duplicate nonce handling.
    doReset();
    stepChk("dd.rs", 1, 0, 0, 1'b0, 32'h0, 0);
    stepChk("dd.h1", 0, 1, 1, 1'b0, 32'hDEADBEEF, 0);
    stepChk("dd.h2", 0, 1, 1, 1'b1, 32'hDEADBEEF, 0);
    cmp("dd.found", {24'd0, foundCount}, DEDUP_EN ? 32'd1 : 32'd2);
    entries = 0;
    for (int k = 0; k < 8; k++) begin
      if (hostValid) entries++;
      applyStimulus(0, 0, 0, 1'b0, 32'h0, 1);
    end
    cmp("dd.entries", 32'(entries), DEDUP_EN ? 32'd1 : 32'd2);

    // Randomized traffic against the reference model.
    doReset();
    for (int i = 0; i < 400; i++) begin
      stepChk($sformatf("rnd%0d", i),
              ($urandom_range(0, 11) == 0),
              ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 1) == 1),
              1'($urandom_range(0, 1)),
              32'($urandom_range(0, 3)),
              ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/lattice_result_collector.md
# lattice_result_collector

Tail stage of the lattice chain: consumes the per-core result stream leaving the last lattice block, counts completed core results per round, and buffers successful nonces in a small FIFO. It presents the buffered nonces to the host-side controller over a valid/ready handshake. It flags round completion and buffer overflow.

## Interface

Parameters:
- LOG2_NUM_CORES, default 1: log2 of the number of cores in the chain; each round produces 2^LOG2_NUM_CORES results.
- FIFO_DEPTH, default 4: number of success entries buffered; power of two, ≥ 2.
- NONCE_BITS, default 32: nonce width.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- round_start_i  in  1  one-cycle pulse; a new job has entered the chain.
- chain_valid_i  in  1  one-cycle pulse; a core result is present on the chain outputs.
- chain_success_i  in  1  the result in this cycle is a hit.
- chain_core_i  in  LOG2_NUM_CORES  index of the core that produced the result.
- chain_nonce_i  in  NONCE_BITS  nonce of the result.
- host_valid_o  out  1  FIFO head is valid.
- host_ready_i  in  1  host accepts the head this cycle.
- host_nonce_o  out  NONCE_BITS  head nonce.
- host_core_o  out  LOG2_NUM_CORES  head core index.
- done_o  out  1  level; all results of the current round have been received.
- overflow_o  out  1  sticky; a success was dropped because the FIFO was full.
- found_count_o  out  8  saturating count of successes pushed this round.

## Operation

- FSM states are IDLE, COLLECT and DONE. Reset enters IDLE.
- IDLE → COLLECT on round_start_i.
- COLLECT → DONE when the result counter reaches 2^LOG2_NUM_CORES. The transition happens on the edge that accepts the final chain_valid_i.
- DONE → COLLECT on round_start_i.
- round_start_i in COLLECT restarts the round.
- Every round start clears the result counter, found_count_o and overflow_o. Round start does not flush the FIFO.
- The result counter has LOG2_NUM_CORES+1 bits. It increments on each chain_valid_i in COLLECT.
- chain_valid_i in IDLE or DONE is ignored entirely: no count, no push.
- Push condition: state is COLLECT, chain_valid_i=1 and chain_success_i=1.
  - A push writes {chain_core_i, chain_nonce_i} to the tail.
  - found_count_o increments and saturates at 255.
- Pop condition: host_valid_o=1 and host_ready_i=1. A pop advances the head.
- Push when full:
  - With a simultaneous pop, both the pop and the push take effect and occupancy stays FIFO_DEPTH.
  - Without a pop, the entry is dropped, overflow_o is set, and found_count_o does not increment.
- Pop when empty is a no-op.
- round_start_i and chain_valid_i in the same cycle: round_start_i wins. The result is discarded and the counter becomes 0.
- Read and write pointers use log2(FIFO_DEPTH)+1 bits with natural wrap. Full and empty are decoded from the MSB difference.
- Reset values:
  - host_valid_o=0, host_nonce_o=0, host_core_o=0.
  - done_o=0, overflow_o=0, found_count_o=0.
  - FIFO emptied.
- Reset asserted mid-round discards all state immediately, without waiting for a clock edge.

## Timing

- A push in cycle N is visible at the head in cycle N+1 when the FIFO was empty: host_valid_o=1 in N+1. There is no combinational path from chain inputs to host outputs.
- A pop in cycle N presents the next entry, or deasserts host_valid_o, in cycle N+1.
- host_nonce_o and host_core_o are stable while host_valid_o=1 and host_ready_i=0.
- done_o rises in the cycle after the final chain_valid_i. It falls in the cycle after round_start_i.
- overflow_o rises in the cycle after the dropped push.
- round_start_i clears the round flags in the cycle after it is sampled.
- Throughput is one push and one pop per cycle.

## Configuration

- LATTICE_COLLECTOR_DEDUP_EN defined:
  - The block holds a last-pushed nonce register plus a valid bit; round start clears the valid bit.
  - A success whose nonce equals that register while the valid bit is set is discarded: no push, no found_count_o increment, no overflow.
- Undefined: every success is pushed, and the register and comparator are not built.

## Test plan

All scenarios use LOG2_NUM_CORES=1 and FIFO_DEPTH=4.

- Reset, then round_start_i, then valid pulses with success=0 and then success=1 (core 1, nonce 0x0000_1234), host_ready_i=1 → host_valid_o is high for exactly one cycle, on the cycle after the hit, with nonce 0x1234 and core 1; done_o=1 the cycle after the second pulse; found_count_o=1.
- Across 3 rounds, 5 hits with host_ready_i=0 → 4 entries are held and the 5th is dropped; overflow_o=1; draining returns the first 4 nonces in order.
- FIFO full, then a hit and host_ready_i=1 in the same cycle → occupancy stays 4; overflow_o=0; the new nonce appears 4th in the drain.
- round_start_i together with chain_valid_i (success=1) → no push; counter=0; done_o=0; two further pulses are required for done_o.
- rst asserted mid-round with 2 entries buffered → host_valid_o=0, done_o=0 and found_count_o=0 asynchronously; the FSM is in IDLE.
- With LATTICE_COLLECTOR_DEDUP_EN defined, two hits with nonce 0xDEAD_BEEF → one entry and found_count_o=1. Without the macro → two entries and found_count_o=2.
